// File: rtl/attosoc_uart.sv
// attosoc_uart: memory-mapped 8N1 UART with programmable baud divider, DIV at 0x0, DATA at 0x4
module attosoc_uart #(
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_addr,
  input  logic [31:0] iomem_wdata,
  input  logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_rdata,
  output logic        ser_tx,
  input  logic        ser_rx
);
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  logic [31:0] r_div, w_div, r_tx_cnt, r_rx_cnt, w_rx_cnt;
  logic [8:0]  r_tx_sh;
  logic [3:0]  r_tx_nb;
  logic        r_tx_busy, r_ser_tx;
  logic        r_rx_s1, r_rx_s2, r_rx_prev, r_rx_valid, w_rx_done;
  logic [7:0]  r_rx_byte, r_rx_sh, w_rx_sh;
  logic [2:0]  r_rx_nb, w_rx_nb;
  rx_state_t   r_rx_state, w_rx_state;
  logic        w_sel_div, w_sel_data, w_tx_last, w_tx_idle, w_tx_wr, w_rx_rd;
  assign w_div      = (r_div < 32'd4) ? 32'd4 : r_div;
  assign w_sel_div  = iomem_addr == 4'h0;
  assign w_sel_data = iomem_addr == 4'h4;
  // the final stop-bit cycle counts as idle so a waiting write starts the next frame seamlessly
  assign w_tx_last  = r_tx_busy && r_tx_cnt == 32'd0 && r_tx_nb == 4'd0;
  assign w_tx_idle  = !r_tx_busy || w_tx_last;
  assign w_tx_wr    = iomem_valid && w_sel_data && iomem_wstrb[0] && w_tx_idle;
  assign w_rx_rd    = iomem_valid && w_sel_data && iomem_wstrb == 4'h0;
  assign iomem_ready = iomem_valid && !(w_sel_data && iomem_wstrb[0] && !w_tx_idle);
  assign iomem_rdata = w_sel_div ? r_div :
                       w_sel_data ? (r_rx_valid ? {24'h0, r_rx_byte} : 32'hFFFF_FFFF) : 32'h0;
  assign ser_tx = r_ser_tx;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_div <= DEFAULT_DIV;
    else if (iomem_valid && w_sel_div)
      for (int i = 0; i < 4; i++)
        if (iomem_wstrb[i]) r_div[8*i +: 8] <= iomem_wdata[8*i +: 8];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_ser_tx  <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_sh   <= '0;
      r_tx_nb   <= '0;
      r_tx_cnt  <= '0;
    end else if (w_tx_wr) begin
      r_ser_tx  <= 1'b0;
      r_tx_busy <= 1'b1;
      r_tx_sh   <= {1'b1, iomem_wdata[7:0]};
      r_tx_nb   <= 4'd9;
      r_tx_cnt  <= w_div - 32'd1;
    end else if (r_tx_busy) begin
      if (r_tx_cnt != 32'd0) r_tx_cnt <= r_tx_cnt - 32'd1;
      else if (r_tx_nb == 4'd0) r_tx_busy <= 1'b0;
      else begin
        r_ser_tx <= r_tx_sh[0];
        r_tx_sh  <= {1'b0, r_tx_sh[8:1]};
        r_tx_nb  <= r_tx_nb - 4'd1;
        r_tx_cnt <= w_div - 32'd1;
      end
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {r_rx_s1, r_rx_s2, r_rx_prev} <= 3'b111;
    else begin
      r_rx_s1   <= ser_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_nb    = r_rx_nb;
    w_rx_sh    = r_rx_sh;
    w_rx_done  = 1'b0;
    case (r_rx_state)
      RX_IDLE:
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state = RX_START;
          w_rx_cnt   = (w_div >> 1) - 32'd1;
        end
      RX_START:
        if (r_rx_cnt != 32'd0) w_rx_cnt = r_rx_cnt - 32'd1;
        else if (r_rx_s2) w_rx_state = RX_IDLE;
        else begin
          w_rx_state = RX_DATA;
          w_rx_cnt   = w_div - 32'd1;
          w_rx_nb    = 3'd0;
        end
      RX_DATA:
        if (r_rx_cnt != 32'd0) w_rx_cnt = r_rx_cnt - 32'd1;
        else begin
          w_rx_sh    = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_cnt   = w_div - 32'd1;
          w_rx_nb    = r_rx_nb + 3'd1;
          w_rx_state = (r_rx_nb == 3'd7) ? RX_STOP : RX_DATA;
        end
      RX_STOP:
        if (r_rx_cnt != 32'd0) w_rx_cnt = r_rx_cnt - 32'd1;
        else begin
          w_rx_done  = r_rx_s2;
          w_rx_state = r_rx_s2 ? RX_IDLE : RX_WAIT;
        end
      RX_WAIT: w_rx_state = r_rx_s2 ? RX_IDLE : RX_WAIT;
      default: w_rx_state = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_nb    <= '0;
      r_rx_sh    <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_nb    <= w_rx_nb;
      r_rx_sh    <= w_rx_sh;
      if (w_rx_done) r_rx_byte <= r_rx_sh;
      r_rx_valid <= w_rx_done ? 1'b1 : (w_rx_rd ? 1'b0 : r_rx_valid);
    end
endmodule

// File: tb/tb_attosoc_uart.sv
// tb_attosoc_uart: directed bench for the attosoc UART register interface, TX framing and RX reception
module tb_attosoc_uart;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_addr = 4'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_rdata;
  logic        ser_tx;
  logic        ser_rx = 1'b1;
  int errors = 0;
  int checks = 0;

  attosoc_uart #(.DEFAULT_DIV(434)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb),
    .iomem_rdata(iomem_rdata), .ser_tx(ser_tx), .ser_rx(ser_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // called at posedge+1; returns at posedge+1 just after the transfer completes
  task automatic bus(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int cyc);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s; cyc = 0;
    @(negedge clk);
    while (!iomem_ready && cyc < 2000) begin @(negedge clk); cyc++; end
    rd = iomem_rdata;
    if (cyc >= 2000) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%h waited=%0d", a, cyc);
    end
    @(posedge clk); #1;
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (div) @(posedge clk);
      #1;
    end
    ser_rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] rd; int cyc;
    repeat (3) @(posedge clk); #1;
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL reset_ser_tx got=%b exp=1", ser_tx); end
    resetn = 1'b1;
    bus(4'h0, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'd434) begin errors++; $display("FAIL reset_div got=%h exp=%h", rd, 32'd434); end
    checks++; if (cyc !== 0) begin errors++; $display("FAIL reset_first_ready waited=%0d exp=0", cyc); end
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data got=%h exp=FFFFFFFF", rd); end
  endtask

  task automatic test_div;
    logic [31:0] rd; int cyc;
    bus(4'h0, 32'd8, 4'hF, rd, cyc);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL div_wr_ready waited=%0d exp=0", cyc); end
    bus(4'h0, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0008) begin errors++; $display("FAIL div_rd got=%h exp=00000008", rd); end
    bus(4'h0, 32'h1234_5678, 4'b0010, rd, cyc);
    bus(4'h0, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_5608) begin errors++; $display("FAIL div_strobe got=%h exp=00005608", rd); end
    bus(4'h0, 32'd8, 4'hF, rd, cyc);
  endtask

  task automatic test_tx;
    logic [31:0] rd; int cyc; int bad; logic [9:0] f;
    f = {1'b1, 8'hA5, 1'b0};
    bus(4'h4, 32'h0000_00A5, 4'h1, rd, cyc);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL tx_wr_ready waited=%0d exp=0", cyc); end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (ser_tx !== f[b]) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL tx_bit%0d wrong_cycles=%0d exp_level=%b", b, bad, f[b]); end
    end
    @(negedge clk);
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL tx_idle got=%b exp=1", ser_tx); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int cyc; int bad; logic [9:0] f;
    f = {1'b1, 8'hC3, 1'b0};
    bus(4'h4, 32'h0000_005A, 4'h1, rd, cyc);
    @(posedge clk); #1;
    bus(4'h4, 32'h0000_00C3, 4'h1, rd, cyc);
    checks++; if (cyc !== 78) begin errors++; $display("FAIL b2b_wait waited=%0d exp=78", cyc); end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (ser_tx !== f[b]) bad++; end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_bit%0d wrong_cycles=%0d exp_level=%b", b, bad, f[b]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rx;
    logic [31:0] rd; int cyc;
    bus(4'h4, 32'h0000_000F, 4'h1, rd, cyc);
    drive_rx(8'h3C, 1'b1, 8);
    repeat (4) @(posedge clk); #1;
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL rx_byte got=%h exp=0000003C", rd); end
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_reread got=%h exp=FFFFFFFF", rd); end
  endtask

  task automatic test_rx_overlap;
    logic [31:0] rd; int cyc;
    drive_rx(8'h11, 1'b1, 8);
    repeat (4) @(posedge clk); #1;
    fork
      drive_rx(8'h96, 1'b1, 8);
      begin repeat (78) @(posedge clk); #1; bus(4'h4, 32'h0, 4'h0, rd, cyc); end
    join
    checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL rx_overlap_old got=%h exp=00000011", rd); end
    repeat (2) @(posedge clk); #1;
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_0096) begin errors++; $display("FAIL rx_overlap_new got=%h exp=00000096", rd); end
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_overlap_empty got=%h exp=FFFFFFFF", rd); end
  endtask

  task automatic test_rx_errors;
    logic [31:0] rd; int cyc;
    bus(4'h0, 32'd16, 4'hF, rd, cyc);
    ser_rx = 1'b0;
    repeat (3) @(posedge clk); #1;
    ser_rx = 1'b1;
    repeat (60) @(posedge clk); #1;
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_glitch got=%h exp=FFFFFFFF", rd); end
    drive_rx(8'h55, 1'b0, 16);
    repeat (20) @(posedge clk); #1;
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_framing got=%h exp=FFFFFFFF", rd); end
    drive_rx(8'hC3, 1'b1, 16);
    repeat (4) @(posedge clk); #1;
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'h0000_00C3) begin errors++; $display("FAIL rx_recover got=%h exp=000000C3", rd); end
  endtask

  task automatic test_misc;
    logic [31:0] rd; int cyc; int bad;
    bus(4'h4, 32'h0000_0000, 4'b0010, rd, cyc);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL data_nostrobe_ready waited=%0d exp=0", cyc); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (ser_tx !== 1'b1) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL data_nostrobe_tx low_cycles=%0d exp=0", bad); end
    @(posedge clk); #1;
    bus(4'h8, 32'hFFFF_FFFF, 4'hF, rd, cyc);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL other_wr_ready waited=%0d exp=0", cyc); end
    bus(4'h8, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL other_rd got=%h exp=00000000", rd); end
    bus(4'h0, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'd16) begin errors++; $display("FAIL other_div_kept got=%h exp=00000010", rd); end
  endtask

  task automatic test_div_clamp;
    logic [31:0] rd; int cyc; int bad0, bad1, bad2;
    bus(4'h0, 32'd1, 4'hF, rd, cyc);
    bus(4'h4, 32'h0000_0001, 4'h1, rd, cyc);
    bad0 = 0; bad1 = 0; bad2 = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (ser_tx !== 1'b0) bad0++; end
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (ser_tx !== 1'b1) bad1++; end
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (ser_tx !== 1'b0) bad2++; end
    checks++; if (bad0 != 0) begin errors++; $display("FAIL clamp_start wrong_cycles=%0d exp=0", bad0); end
    checks++; if (bad1 != 0) begin errors++; $display("FAIL clamp_bit0 wrong_cycles=%0d exp=0", bad1); end
    checks++; if (bad2 != 0) begin errors++; $display("FAIL clamp_bit1 wrong_cycles=%0d exp=0", bad2); end
    repeat (40) @(posedge clk); #1;
    bus(4'h0, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL clamp_div_rd got=%h exp=00000001", rd); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] rd; int cyc; int bad;
    bus(4'h0, 32'd8, 4'hF, rd, cyc);
    bus(4'h4, 32'h0000_0000, 4'h1, rd, cyc);
    repeat (36) @(negedge clk);
    checks++; if (ser_tx !== 1'b0) begin errors++; $display("FAIL midframe_low got=%b exp=0", ser_tx); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx got=%b exp=1", ser_tx); end
    repeat (2) @(posedge clk); #1;
    resetn = 1'b1;
    bus(4'h4, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midframe_data got=%h exp=FFFFFFFF", rd); end
    checks++; if (cyc !== 0) begin errors++; $display("FAIL midframe_ready waited=%0d exp=0", cyc); end
    bus(4'h0, 32'h0, 4'h0, rd, cyc);
    checks++; if (rd !== 32'd434) begin errors++; $display("FAIL midframe_div got=%h exp=%h", rd, 32'd434); end
    bad = 0;
    for (int k = 0; k < 60; k++) begin @(negedge clk); if (ser_tx !== 1'b1) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL midframe_abort low_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset;
    test_div;
    test_tx;
    test_back_to_back;
    test_rx;
    test_rx_overlap;
    test_rx_errors;
    test_misc;
    test_div_clamp;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
